hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
//  Pipeline hazard/sequencing controller for the 5-stage ARM core (F/D/E/M/W). Drives forwarding muxes in front of
//  the ALU, stall enables on the F/D, D/E, E/M pipe registers, and flushes of the D and E stage registers.
//  Adds an FSM that freezes the pipe while the slow camera/data memory holds a request in M, with a timeout guard.
// PARAMETERS
//  TIMEOUT  256  max cycles in MEM_WAIT before forced release; valid 2..2**WAIT_W-1
//  WAIT_W   9    width of internal wait counter
//  CNT_W    16   width of StallCount performance counter (saturating)
// PORTS
//  Clk          in   1      core clock, all state on rising edge
//  Rst          in   1      synchronous, active-high reset
//  RA1D, RA2D   in   4      source regs of instruction in D (post RegSrc muxes)
//  RA1E, RA2E   in   4      source regs of instruction in E
//  WA3E, WA3M, WA3W in 4    destination regs in E, M, W
//  RegWriteM, RegWriteW in 1  register-write enables of M, W
//  MemToRegE    in   1      instruction in E is a load
//  PCSrcD, PCSrcE, PCSrcM in 1  instruction in D/E/M writes R15
//  BranchTakenE in   1      branch in E resolved taken this cycle
//  MemReqM      in   1      M-stage memory access active
//  MemReadyM    in   1      memory completes access this cycle
//  ForwardAE, ForwardBE out 2  00 reg file, 01 ResultW, 10 ALUResultM
//  StallF, StallD, StallE, StallM out 1  hold corresponding pipe register
//  FlushD, FlushE, FlushW out 1  clear D/E register; insert bubble (RegWrite=0) into W
//  MemTimeout   out  1      sticky: a MEM_WAIT ended by timeout
//  StallCount   out  CNT_W  cycles with StallF=1, saturating
// BEHAVIOUR
//  Reset (Rst=1 at edge): state<=RUN, wait counter<=0, MemTimeout<=0, StallCount<=0. While Rst is high, outputs are
//   forced: Forward*=00, Stall*=0, FlushD=FlushE=FlushW=1.
//  Forwarding (combinational, all states): ForwardAE=10 if RegWriteM & RA1E==WA3M & RA1E!=15; else 01 if
//   RegWriteW & RA1E==WA3W & RA1E!=15; else 00. M beats W on match of both. ForwardBE same with RA2E. R15 never forwarded.
//  FSM states: RUN, MEM_WAIT.
//   RUN -> MEM_WAIT when MemReqM & ~MemReadyM; wait counter<=1.
//   MEM_WAIT -> RUN when MemReadyM (counter<=0), or when counter==TIMEOUT (set MemTimeout, counter<=0).
//   MEM_WAIT otherwise: counter increments.
//  Outputs in MEM_WAIT, and in RUN the cycle MemReqM&~MemReadyM (zero latency): StallF=StallD=StallE=StallM=1,
//   FlushW=1, FlushD=FlushE=0; branch/load-use logic suppressed (E frozen, re-evaluated after release).
//   Cycle MemReadyM=1: no memory stall; normal RUN equations apply.
//  RUN equations (no memory stall):
//   LdStall = MemToRegE & (RA1D==WA3E | RA2D==WA3E).
//   PCWrPend = PCSrcD | PCSrcE | PCSrcM.
//   StallD = LdStall; StallF = (LdStall | PCWrPend) & ~BranchTakenE; StallE=StallM=0.
//   FlushD = PCWrPend | BranchTakenE; FlushE = LdStall | BranchTakenE; FlushW = 0.
//   Simultaneous branch + load-use: branch wins for F (target fetched), E flushed once.
//  StallCount: +1 each non-reset cycle with StallF=1; holds at 2**CNT_W-1.
//  MemTimeout: cleared only by Rst.
//  Reset mid-MEM_WAIT: next cycle is RUN with counter 0, no stall unless new request.
// TESTING
//  Forward: RegWriteM=1,WA3M=3,RegWriteW=1,WA3W=3,RA1E=3 -> ForwardAE=10; WA3M=4 -> 01; RA1E=15 -> 00.
//  Load-use: MemToRegE=1,WA3E=5,RA2D=5 -> StallF=StallD=FlushE=1, FlushD=0 for exactly 1 cycle.
//  Branch: BranchTakenE=1 with LdStall=1 -> FlushD=FlushE=1, StallF=0; next cycle all 0.
//  Mem wait: MemReqM=1, MemReadyM low 3 cycles then high -> Stall*=FlushW=1 for 3 cycles, 0 on ready; StallCount=3.
//  Timeout: TIMEOUT=4, MemReadyM never high -> release after 4 MEM_WAIT cycles, MemTimeout=1 sticky until Rst.
//  Rst asserted in MEM_WAIT -> Flush*=1 Stall*=0 during Rst; state RUN, StallCount=0, MemTimeout=0 after.

Source files
------------

// File: rtl/hazard_controller.sv
`default_nettype none
// hazard_controller: forwarding, load-use/branch stall+flush and slow-memory freeze FSM for the 5-stage core.
// Rev 1.0
module hazard_controller #(
   parameter int TIMEOUT = 256,
   parameter int WAIT_W  = 9,
   parameter int CNT_W   = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [3:0]       RA1D,
   input  logic [3:0]       RA2D,
   input  logic [3:0]       RA1E,
   input  logic [3:0]       RA2E,
   input  logic [3:0]       WA3E,
   input  logic [3:0]       WA3M,
   input  logic [3:0]       WA3W,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemToRegE,
   input  logic             PCSrcD,
   input  logic             PCSrcE,
   input  logic             PCSrcM,
   input  logic             BranchTakenE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCount
);

   localparam logic [0:0] S_RUN      = 1'b0;
   localparam logic [0:0] S_MEM_WAIT = 1'b1;

   localparam logic [WAIT_W-1:0] C_TIMEOUT = WAIT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  C_CNT_MAX = {CNT_W{1'b1}};

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_nxt;
   logic              timeout_hit;
   logic              mem_stall;
   logic              ld_stall;
   logic              pc_wr_pend;

   // M-stage result has priority over W; R15 reads always come from the PC path
   function automatic logic [1:0] fwd_sel(
      input logic [3:0] ra,
      input logic       we_m,
      input logic [3:0] wa_m,
      input logic       we_w,
      input logic [3:0] wa_w
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (ra != 4'd15) begin
         if (we_m && (ra == wa_m))
            sel = 2'b10;
         else if (we_w && (ra == wa_w))
            sel = 2'b01;
      end
      return sel;
   endfunction

   always_comb begin
      mem_stall  = (state == S_MEM_WAIT) ? ~MemReadyM : (MemReqM & ~MemReadyM);
      ld_stall   = MemToRegE & ((RA1D == WA3E) | (RA2D == WA3E));
      pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      timeout_hit  = 1'b0;
      case (state)
         S_RUN: begin
            if (MemReqM && !MemReadyM) begin
               state_nxt    = S_MEM_WAIT;
               wait_cnt_nxt = WAIT_W'(1);
            end
         end
         S_MEM_WAIT: begin
            if (MemReadyM) begin
               state_nxt    = S_RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == C_TIMEOUT) begin
               state_nxt    = S_RUN;
               wait_cnt_nxt = '0;
               timeout_hit  = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         default: begin
            state_nxt    = S_RUN;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   // While frozen on memory, E is held, so branch/load-use are re-evaluated after release
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      if (!Rst) begin
         ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
         ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
         if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
         end else begin
            StallD = ld_stall;
            StallF = (ld_stall | pc_wr_pend) & ~BranchTakenE;
            FlushD = pc_wr_pend | BranchTakenE;
            FlushE = ld_stall | BranchTakenE;
            FlushW = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= S_RUN;
         wait_cnt   <= '0;
         MemTimeout <= 1'b0;
         StallCount <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (timeout_hit)
            MemTimeout <= 1'b1;
         if (StallF && (StallCount != C_CNT_MAX))
            StallCount <= StallCount + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// tb_hazard_controller: directed and randomized checks against a behavioural model of the hazard rules.
module tb_hazard_controller;

   localparam int TMO   = 4;
   localparam int CW    = 6;
   localparam int SCMAX = (1 << CW) - 1;

   logic          Clk = 1'b0;
   logic          Rst;
   logic [3:0]    RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
   logic          RegWriteM, RegWriteW, MemToRegE;
   logic          PCSrcD, PCSrcE, PCSrcM, BranchTakenE;
   logic          MemReqM, MemReadyM;
   logic [1:0]    ForwardAE, ForwardBE;
   logic          StallF, StallD, StallE, StallM;
   logic          FlushD, FlushE, FlushW;
   logic          MemTimeout;
   logic [CW-1:0] StallCount;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit m_wait;
   int m_cnt;
   bit m_to;
   int m_sc;
   logic [1:0] e_fa, e_fb;
   logic e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;

   hazard_controller #(.TIMEOUT(TMO), .WAIT_W(9), .CNT_W(CW)) dut (
      .Clk(Clk), .Rst(Rst),
      .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .BranchTakenE(BranchTakenE),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .MemTimeout(MemTimeout), .StallCount(StallCount)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
      if (ra == 4'd15) return 2'b00;
      if (RegWriteM && ra == WA3M) return 2'b10;
      if (RegWriteW && ra == WA3W) return 2'b01;
      return 2'b00;
   endfunction

   task automatic clear_inputs();
      RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
      RegWriteM = 0; RegWriteW = 0; MemToRegE = 0;
      PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; BranchTakenE = 0;
      MemReqM = 0; MemReadyM = 0;
   endtask

   // compute expectations for the current cycle and compare at the negative edge
   task automatic eval();
      bit frozen, ld, pc;
      @(negedge Clk);
      if (Rst) begin
         e_fa = 0; e_fb = 0;
         {e_sf, e_sd, e_se, e_sm} = 4'b0000;
         {e_fd, e_fe, e_fw} = 3'b111;
      end else begin
         e_fa = ref_fwd(RA1E);
         e_fb = ref_fwd(RA2E);
         frozen = m_wait ? !MemReadyM : (MemReqM && !MemReadyM);
         if (frozen) begin
            {e_sf, e_sd, e_se, e_sm} = 4'b1111;
            {e_fd, e_fe, e_fw} = 3'b001;
         end else begin
            ld = MemToRegE && (RA1D == WA3E || RA2D == WA3E);
            pc = PCSrcD || PCSrcE || PCSrcM;
            e_sd = ld;
            e_sf = (ld || pc) && !BranchTakenE;
            e_se = 0; e_sm = 0;
            e_fd = pc || BranchTakenE;
            e_fe = ld || BranchTakenE;
            e_fw = 0;
         end
      end
      chk("ForwardAE", ForwardAE, e_fa);
      chk("ForwardBE", ForwardBE, e_fb);
      chk("StallF", StallF, e_sf);
      chk("StallD", StallD, e_sd);
      chk("StallE", StallE, e_se);
      chk("StallM", StallM, e_sm);
      chk("FlushD", FlushD, e_fd);
      chk("FlushE", FlushE, e_fe);
      chk("FlushW", FlushW, e_fw);
      chk("MemTimeout", MemTimeout, m_to);
      chk("StallCount", StallCount, m_sc);
   endtask

   // advance the model through the rising edge, then move past it
   task automatic adv();
      if (Rst) begin
         m_wait = 0; m_cnt = 0; m_to = 0; m_sc = 0;
      end else begin
         if (e_sf && m_sc < SCMAX) m_sc++;
         if (!m_wait) begin
            if (MemReqM && !MemReadyM) begin m_wait = 1; m_cnt = 1; end
         end else if (MemReadyM) begin
            m_wait = 0; m_cnt = 0;
         end else if (m_cnt >= TMO) begin
            m_wait = 0; m_cnt = 0; m_to = 1;
         end else begin
            m_cnt++;
         end
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic cyc();
      eval();
      adv();
   endtask

   function automatic logic [3:0] rnd_reg();
      int r;
      r = $urandom_range(0, 5);
      return (r == 5) ? 4'd15 : 4'(r);
   endfunction

   initial begin
      clear_inputs();
      Rst = 1;
      m_wait = 0; m_cnt = 0; m_to = 0; m_sc = 0;
      @(posedge Clk);
      #1;

      // reset state
      eval();
      chk("rst_flushD", FlushD, 1'b1);
      chk("rst_stallF", StallF, 1'b0);
      adv();
      Rst = 0;

      // forwarding priority and R15 exclusion
      RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3;
      eval(); chk("fwd_m_wins", ForwardAE, 2'b10); adv();
      WA3M = 4;
      eval(); chk("fwd_w", ForwardAE, 2'b01); adv();
      RA1E = 15; WA3M = 15; WA3W = 15; RA2E = 4;
      eval(); chk("fwd_r15", ForwardAE, 2'b00); chk("fwd_b_m", ForwardBE, 2'b00); adv();
      clear_inputs();

      // load-use for exactly one cycle
      MemToRegE = 1; WA3E = 5; RA2D = 5; RA1D = 1;
      eval(); chk("lu_stallF", StallF, 1'b1); chk("lu_flushD", FlushD, 1'b0); adv();
      MemToRegE = 0;
      eval(); chk("lu_release", StallD, 1'b0); adv();

      // branch beats load-use on F
      MemToRegE = 1; BranchTakenE = 1;
      eval(); chk("br_stallF", StallF, 1'b0); chk("br_flushE", FlushE, 1'b1); adv();
      clear_inputs();
      cyc();

      // memory wait of three frozen cycles
      Rst = 1; cyc(); Rst = 0;
      MemReqM = 1; MemReadyM = 0;
      repeat (3) cyc();
      MemReadyM = 1;
      eval(); chk("mw_ready_stall", StallM, 1'b0); adv();
      chk("mw_count", StallCount, 3);
      clear_inputs();

      // timeout after TMO wait cycles, sticky flag
      MemReqM = 1; cyc(); MemReqM = 0;
      repeat (TMO) cyc();
      eval(); chk("to_released", StallF, 1'b0); adv();
      chk("to_flag", MemTimeout, 1'b1);
      repeat (3) cyc();
      chk("to_sticky", MemTimeout, 1'b1);

      // reset while frozen
      MemReqM = 1; cyc(); MemReqM = 0; cyc();
      Rst = 1;
      eval(); chk("rw_flushW", FlushW, 1'b1); chk("rw_stallM", StallM, 1'b0); adv();
      Rst = 0;
      eval(); chk("rw_run", StallF, 1'b0); adv();
      chk("rw_to_clr", MemTimeout, 1'b0);

      // counter saturation
      MemReqM = 1; MemReadyM = 0;
      repeat (SCMAX + 10) cyc();
      chk("sat", StallCount, SCMAX);
      clear_inputs();
      Rst = 1; cyc(); Rst = 0;

      // randomized traffic
      repeat (600) begin
         RA1D = rnd_reg(); RA2D = rnd_reg(); RA1E = rnd_reg(); RA2E = rnd_reg();
         WA3E = rnd_reg(); WA3M = rnd_reg(); WA3W = rnd_reg();
         RegWriteM = ($urandom_range(0, 1) == 1);
         RegWriteW = ($urandom_range(0, 1) == 1);
         MemToRegE = ($urandom_range(0, 2) == 0);
         PCSrcD = ($urandom_range(0, 7) == 0);
         PCSrcE = ($urandom_range(0, 7) == 0);
         PCSrcM = ($urandom_range(0, 7) == 0);
         BranchTakenE = ($urandom_range(0, 5) == 0);
         MemReqM = ($urandom_range(0, 3) == 0);
         MemReadyM = ($urandom_range(0, 5) == 0);
         Rst = ($urandom_range(0, 49) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
